mul_div_unit: RTL and testbench

//  Iterative 32-bit multiply/divide unit with HI/LO result registers for the MIPS datapath.

---
 rtl/mul_div_if.sv | 31 +++
 rtl/mul_div_unit.sv | 134 +++++++++++++
 tb/tb_mul_div_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_if
// Brief   : Handshake and operand/result bundle for the iterative mul/div unit.
// Revision: 1.0
// ============================================================================
interface mul_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  mthi_en;
    logic                  mtlo_en;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, mthi_en, mtlo_en,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, mthi_en, mtlo_en,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit
// Brief   : Iterative shift-add multiply / restoring divide with HI/LO registers.
// Revision: 1.0
// ============================================================================
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    mul_div_if.slave     bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_lo;
    logic [2*W-1:0]     r_acc;
    logic [W-1:0]       r_opnd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_b_zero;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [W-1:0]       w_mag_a;
    logic [W-1:0]       w_mag_b;
    logic [W:0]         w_add;
    logic [2*W-1:0]     w_mul_next;
    logic [W:0]         w_rem;
    logic               w_ge;
    logic [W-1:0]       w_diff;
    logic [2*W-1:0]     w_div_next;
    logic [2*W-1:0]     w_prod;
    logic [W-1:0]       w_quot;
    logic [W-1:0]       w_remd;

    assign w_accept = bus.start && !r_busy;
    assign w_a_neg  = bus.op[0] & bus.src_a[W-1];
    assign w_b_neg  = bus.op[0] & bus.src_b[W-1];
    assign w_mag_a  = w_a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign w_mag_b  = w_b_neg ? (~bus.src_b + 1'b1) : bus.src_b;

    // Multiply: upper half accumulates the multiplicand, whole register shifts right.
    assign w_add      = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opnd : {W{1'b0}})};
    assign w_mul_next = {w_add, r_acc[W-1:1]};

    // Divide: the shifted partial remainder needs W+1 bits before the trial subtract.
    assign w_rem      = r_acc[2*W-1:W-1];
    assign w_ge       = (w_rem >= {1'b0, r_opnd});
    assign w_diff     = w_rem[W-1:0] - r_opnd;
    assign w_div_next = w_ge ? {w_diff, r_acc[W-2:0], 1'b1} : {r_acc[2*W-2:0], 1'b0};

    assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quot = r_b_zero  ? {W{1'b1}}
                  : (r_neg_res ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0]);
    assign w_remd = r_neg_rem ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (bus.mthi_en) r_hi <= bus.src_a;
                if (bus.mtlo_en) r_lo <= bus.src_a;
            end
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (w_accept) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_is_div  <= bus.op[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= bus.op[1] & w_a_neg;
                        r_b_zero  <= bus.op[1] & (bus.src_b == '0);
                        r_acc     <= bus.op[1] ? {{W{1'b0}}, w_mag_a} : {{W{1'b0}}, w_mag_b};
                        r_opnd    <= bus.op[1] ? w_mag_b : w_mag_a;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= r_is_div ? w_remd : w_prod[2*W-1:W];
                        r_lo    <= r_is_div ? w_quot : w_prod[W-1:0];
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Self-checking bench for mul_div_unit against an arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_mul_div_unit;
    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_if #(.DATA_WIDTH(32)) bus ();

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} straight from the architectural definitions.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic [31:0] q;
        logic [31:0] r;
        case (op)
            OP_MULTU: return {32'h0, a} * {32'h0, b};
            OP_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_done", bus.done, 1'b0);
            check("idle_hi", bus.hi, exp_hi);
            check("idle_lo", bus.lo, exp_lo);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mv, input bit disturb);
        logic [63:0] e;
        int cyc;
        int busy_n;
        logic [31:0] hold_hi;
        e = model(op, a, b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.src_a   = a;
        bus.src_b   = b;
        bus.mthi_en = mv;
        bus.mtlo_en = mv;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.mthi_en = 1'b0;
        bus.mtlo_en = 1'b0;
        bus.src_a   = $urandom;
        bus.src_b   = $urandom;
        bus.op      = 2'($urandom);
        if (mv) begin
            check("move_at_accept_hi", bus.hi, a);
            check("move_at_accept_lo", bus.lo, a);
        end
        hold_hi = bus.hi;
        cyc = 0;
        busy_n = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) busy_n++;
            if (disturb && cyc == 5) begin
                bus.start = 1'b1; bus.op = OP_MULTU; bus.mthi_en = 1'b1; bus.src_a = 32'hAAAA;
            end else if (disturb && cyc == 6) begin
                bus.start = 1'b0; bus.mthi_en = 1'b0;
            end else if (disturb && cyc == 7) begin
                check("mthi_while_busy", bus.hi, hold_hi);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, 33);
        check("busy_cycles", busy_n, 33);
        check("busy_in_done", bus.busy, 1'b0);
        check("result_hi", bus.hi, e[63:32]);
        check("result_lo", bus.lo, e[31:0]);
        exp_hi = e[63:32];
        exp_lo = e[31:0];
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
        bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", bus.hi, 32'h0);
        check("reset_lo", bus.lo, 32'h0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        bus.src_a = 32'h1234_5678; bus.mthi_en = 1'b1;
        @(posedge clk); #1; bus.mthi_en = 1'b0; exp_hi = 32'h1234_5678;
        check("mthi_hi", bus.hi, exp_hi);
        check("mthi_lo", bus.lo, exp_lo);
        bus.src_a = 32'hCAFE_F00D; bus.mtlo_en = 1'b1;
        @(posedge clk); #1; bus.mtlo_en = 1'b0; exp_lo = 32'hCAFE_F00D;
        check("mtlo_hi", bus.hi, exp_hi);
        check("mtlo_lo", bus.lo, exp_lo);
        bus.src_a = 32'h0BAD_BEEF; bus.mthi_en = 1'b1; bus.mtlo_en = 1'b1;
        @(posedge clk); #1; bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0;
        exp_hi = 32'h0BAD_BEEF; exp_lo = 32'h0BAD_BEEF;
        check("both_hi", bus.hi, exp_hi);
        check("both_lo", bus.lo, exp_lo);
        idle(1);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(1);
        run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
        idle(1);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(1);
        run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
        idle(1);
        run_op(OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        idle(1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(2);
        run_op(OP_DIVU, 32'd17, 32'd5, 1'b0, 1'b1);
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);
        idle(2);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        idle(1);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, 1'($urandom_range(0, 5) == 0), 1'b0);
            idle($urandom_range(0, 2));
        end

        bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd7;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        idle(30);
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_1000, 1'b0, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
